// File: rtl/hazard_control_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_control_unit_if
// Signal bundle between the pipeline datapath and the hazard control unit.
//   master : pipeline side. Drives the decoded ID-stage instruction and branch
//            resolution, and receives the stall/flush controls and the tracked
//            destinations used by the forwarding unit.
//   slave  : hazard control unit side.
// ID fields  : id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
//              id_reg_write, id_mem_read, id_is_mul
// EX field   : ex_branch_taken
// Controls   : pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold
// Tracking   : ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write
// -----------------------------------------------------------------------------
interface hazard_control_unit_if;
    logic       id_valid;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [3:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_is_mul;
    logic       ex_branch_taken;

    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       ex_hold;
    logic [3:0] ex_mem_rd;
    logic       ex_mem_reg_write;
    logic [3:0] mem_wb_rd;
    logic       mem_wb_reg_write;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, id_is_mul, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
               ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
               id_reg_write, id_mem_read, id_is_mul, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
               ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write
    );
endinterface

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Tracks shadow copies of the ID/EX, EX/MEM and MEM/WB pipeline slots and
// produces the PC / IF-ID / ID-EX / EX control signals that resolve
// multi-cycle multiplies, taken branches and read-after-write hazards.
// Priority of the combinational controls: multiply busy > branch flush >
// RAW stall > normal flow.
//
// Parameters : MUL_LAT (1..8) cycles a multiply occupies EX.
// Ports      : clk    - sole clock, rising edge
//              rst_n  - asynchronous active-low reset
//              hz     - hazard_control_unit_if.slave (ID inputs, controls,
//                       tracked destinations for the forwarding unit)
// Build macro: HAZARD_FULL_STALL_EN
//              undefined - forwarding present; stall only on load-use
//                          against ID/EX.
//              defined   - no forwarding; stall on any producer in ID/EX or
//                          EX/MEM. MEM/WB never stalls (register file is
//                          written before it is read).
// -----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_unit_if.slave  hz
);

    typedef struct packed {
        logic [3:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       is_mul;
    } slot_t;

    // Past MEM nothing looks at mem_read/is_mul, so MEM/WB keeps only the
    // fields the forwarding unit consumes.
    typedef struct packed {
        logic [3:0] rd;
        logic       reg_write;
    } wb_slot_t;

    localparam slot_t      BUBBLE   = '0;
    localparam logic [2:0] MUL_LOAD = 3'(MUL_LAT - 1);

`ifdef HAZARD_FULL_STALL_EN
    localparam int N_CHK = 2;   // ID/EX and EX/MEM producers
`else
    localparam int N_CHK = 1;   // ID/EX producer only
`endif

    slot_t      id_ex_reg,  id_ex_next;
    slot_t      ex_mem_reg, ex_mem_next;
    wb_slot_t   mem_wb_reg, mem_wb_next;
    logic [2:0] busy_cnt_reg, busy_cnt_next;

    slot_t      id_slot;
    slot_t      chk_slot [N_CHK];
    logic [N_CHK-1:0] raw_match;
    logic       ex_busy;
    logic       raw_stall;
    logic       flush_req;

    logic       pc_write_c;
    logic       if_id_write_c;
    logic       if_id_flush_c;
    logic       id_ex_bubble_c;
    logic       ex_hold_c;

    assign id_slot = '{rd:        hz.id_rd,
                       reg_write: hz.id_reg_write,
                       mem_read:  hz.id_mem_read,
                       is_mul:    hz.id_is_mul};

    assign ex_busy = (busy_cnt_reg != 3'd0);

    // Producer slots checked against the ID sources, youngest first.
    assign chk_slot[0] = id_ex_reg;
`ifdef HAZARD_FULL_STALL_EN
    assign chk_slot[1] = ex_mem_reg;
`endif

    generate
        for (genvar gi = 0; gi < N_CHK; gi++) begin : g_raw
            // r0 is hard-wired zero, so it is never a real dependency.
            assign raw_match[gi] = hz.id_valid
                                && chk_slot[gi].reg_write
                                && (chk_slot[gi].rd != 4'd0)
                                && ((hz.id_uses_rs && (chk_slot[gi].rd == hz.id_rs))
                                 || (hz.id_uses_rt && (chk_slot[gi].rd == hz.id_rt)));
        end
    endgenerate

`ifdef HAZARD_FULL_STALL_EN
    assign raw_stall = |raw_match;
`else
    // With forwarding, only a load still in EX cannot supply its result.
    assign raw_stall = raw_match[0] && id_ex_reg.mem_read;
`endif

    // Gated by rst_n so that outputs show normal flow while reset is held.
    assign flush_req = hz.ex_branch_taken && rst_n;

    // Control outputs
    always_comb begin
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_hold_c      = 1'b0;
        if (ex_busy) begin
            // Branch resolution is meaningless while EX is frozen.
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            ex_hold_c     = 1'b1;
        end else if (flush_req) begin
            // The stalled consumer is on the wrong path; drop it instead.
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
        end else if (raw_stall) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
        end
    end

    // Next state of the shadow pipeline and the multiply counter
    always_comb begin
        mem_wb_next   = '{rd: ex_mem_reg.rd, reg_write: ex_mem_reg.reg_write};
        ex_mem_next   = id_ex_reg;
        id_ex_next    = id_ex_reg;
        busy_cnt_next = 3'd0;
        if (ex_busy) begin
            ex_mem_next   = BUBBLE;
            busy_cnt_next = busy_cnt_reg - 3'd1;
        end else begin
            if (id_ex_bubble_c || !hz.id_valid) begin
                id_ex_next = BUBBLE;
            end else begin
                id_ex_next = id_slot;
            end
            // Counts the extra EX cycles after the first one.
            if (id_ex_next.is_mul) begin
                busy_cnt_next = MUL_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_reg    <= BUBBLE;
            ex_mem_reg   <= BUBBLE;
            mem_wb_reg   <= '0;
            busy_cnt_reg <= 3'd0;
        end else begin
            id_ex_reg    <= id_ex_next;
            ex_mem_reg   <= ex_mem_next;
            mem_wb_reg   <= mem_wb_next;
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign hz.pc_write         = pc_write_c;
    assign hz.if_id_write      = if_id_write_c;
    assign hz.if_id_flush      = if_id_flush_c;
    assign hz.id_ex_bubble     = id_ex_bubble_c;
    assign hz.ex_hold          = ex_hold_c;
    assign hz.ex_mem_rd        = ex_mem_reg.rd;
    assign hz.ex_mem_reg_write = ex_mem_reg.reg_write;
    assign hz.mem_wb_rd        = mem_wb_reg.rd;
    assign hz.mem_wb_reg_write = mem_wb_reg.reg_write;

endmodule
